dual_ad7528_attenuator: RTL and testbench



---
 rtl/dual_ad7528_attenuator_pkg.sv | 24 ++
 rtl/ad7528_serial_rx.sv | 78 +++++++
 rtl/dual_ad7528_attenuator.sv | 88 ++++++++
 tb/tb_dual_ad7528_attenuator.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_ad7528_attenuator_pkg.sv
// Shared constants and helpers for the AD7528 stereo attenuator/mixer.
// Covers channel-select encoding, reset gain codes and 16-bit saturation.
package dual_ad7528_attenuator_pkg;

    typedef logic [7:0] gain_code_t;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    localparam gain_code_t GAIN_DIRECT_RESET = 8'hFF;
    localparam gain_code_t GAIN_CROSS_RESET  = 8'h00;

    localparam logic [3:0] FRAME_BITS = 4'd9;

    // Clamp a 26-bit mix result into the signed 16-bit output range.
    function automatic logic [15:0] sat16(input logic signed [25:0] v);
        if (v > 26'sd32767)
            return 16'h7FFF;
        else if (v < -26'sd32768)
            return 16'h8000;
        return v[15:0];
    endfunction

endpackage

// File: rtl/ad7528_serial_rx.sv
// Serial receiver for one AD7528 chip: edge detection, shared-style frame shift register,
// and the A/B gain code registers latched on its own chip-select rising edge.
module ad7528_serial_rx
    import dual_ad7528_attenuator_pkg::*;
(
    input  logic       clk30,
    input  logic       reset,
    input  logic       datadac,
    input  logic       clkdac,
    input  logic       csn,
    input  logic       csn_other,
    output logic [7:0] gain_a,
    output logic [7:0] gain_b
);

    logic       data_r;
    logic       clk_r;
    logic       clk_rr;
    logic       cs_r;
    logic       cs_rr;
    logic       cso_r;
    logic       cso_rr;
    logic [8:0] shift_reg;
    logic [3:0] bit_count;

    logic clk_rise;
    logic cs_fall;
    logic cs_rise;
    logic any_sel;

    // The other chip select is watched too, so both receivers hold the same frame.
    assign clk_rise = clk_r & ~clk_rr;
    assign cs_fall  = (~cs_r & cs_rr) | (~cso_r & cso_rr);
    assign cs_rise  = cs_r & ~cs_rr;
    assign any_sel  = ~cs_r | ~cso_r;

    always_ff @(posedge clk30) begin
        if (reset) begin
            data_r    <= 1'b0;
            clk_r     <= 1'b0;
            clk_rr    <= 1'b0;
            cs_r      <= 1'b1;
            cs_rr     <= 1'b1;
            cso_r     <= 1'b1;
            cso_rr    <= 1'b1;
            shift_reg <= '0;
            bit_count <= '0;
            gain_a    <= GAIN_DIRECT_RESET;
            gain_b    <= GAIN_CROSS_RESET;
        end else begin
            data_r <= datadac;
            clk_r  <= clkdac;
            clk_rr <= clk_r;
            cs_r   <= csn;
            cs_rr  <= cs_r;
            cso_r  <= csn_other;
            cso_rr <= cso_r;

            if (cs_fall) begin
                shift_reg <= '0;
                bit_count <= '0;
            end else if (clk_rise && any_sel) begin
                shift_reg <= {shift_reg[7:0], data_r};
                if (bit_count != 4'd15)
                    bit_count <= bit_count + 4'd1;
            end

            // Short frames are dropped; longer ones keep only the last nine bits.
            if (cs_rise && (bit_count >= FRAME_BITS)) begin
                if (shift_reg[8] == CH_A)
                    gain_a <= shift_reg[7:0];
                else
                    gain_b <= shift_reg[7:0];
            end
        end
    end

endmodule

// File: rtl/dual_ad7528_attenuator.sv
// Stereo 2x2 gain matrix driven by two serially programmed AD7528 models.
// Outputs are registered, saturated mixes of the current samples and gains.
module dual_ad7528_attenuator
    import dual_ad7528_attenuator_pkg::*;
(
    input  logic        clk30,
    input  logic        reset,
    input  logic        datadac,
    input  logic        clkdac,
    input  logic        csdac1n,
    input  logic        csdac2n,
    input  logic [15:0] audio_left_in,
    input  logic [15:0] audio_right_in,
    output logic [15:0] audio_left_out,
    output logic [15:0] audio_right_out
);

    logic [7:0] g_ll;
    logic [7:0] g_rl;
    logic [7:0] g_rr;
    logic [7:0] g_lr;

    ad7528_serial_rx u_dac1 (
        .clk30     (clk30),
        .reset     (reset),
        .datadac   (datadac),
        .clkdac    (clkdac),
        .csn       (csdac1n),
        .csn_other (csdac2n),
        .gain_a    (g_ll),
        .gain_b    (g_rl)
    );

    ad7528_serial_rx u_dac2 (
        .clk30     (clk30),
        .reset     (reset),
        .datadac   (datadac),
        .clkdac    (clkdac),
        .csn       (csdac2n),
        .csn_other (csdac1n),
        .gain_a    (g_rr),
        .gain_b    (g_lr)
    );

    logic signed [15:0] left_s;
    logic signed [15:0] right_s;
    logic signed [8:0]  gll_s;
    logic signed [8:0]  grl_s;
    logic signed [8:0]  grr_s;
    logic signed [8:0]  glr_s;
    logic signed [24:0] p_ll;
    logic signed [24:0] p_rl;
    logic signed [24:0] p_rr;
    logic signed [24:0] p_lr;
    logic signed [25:0] sum_left;
    logic signed [25:0] sum_right;
    logic signed [25:0] mix_left;
    logic signed [25:0] mix_right;

    // Codes are unsigned, so they get a zero sign bit before the signed multiply.
    always_comb begin
        left_s    = audio_left_in;
        right_s   = audio_right_in;
        gll_s     = {1'b0, g_ll};
        grl_s     = {1'b0, g_rl};
        grr_s     = {1'b0, g_rr};
        glr_s     = {1'b0, g_lr};
        p_ll      = 25'(left_s)  * 25'(gll_s);
        p_rl      = 25'(right_s) * 25'(grl_s);
        p_rr      = 25'(right_s) * 25'(grr_s);
        p_lr      = 25'(left_s)  * 25'(glr_s);
        sum_left  = {p_ll[24], p_ll} + {p_rl[24], p_rl};
        sum_right = {p_rr[24], p_rr} + {p_lr[24], p_lr};
        mix_left  = sum_left >>> 8;
        mix_right = sum_right >>> 8;
    end

    always_ff @(posedge clk30) begin
        if (reset) begin
            audio_left_out  <= '0;
            audio_right_out <= '0;
        end else begin
            audio_left_out  <= sat16(mix_left);
            audio_right_out <= sat16(mix_right);
        end
    end

endmodule

// File: tb/tb_dual_ad7528_attenuator.sv
// Scoreboard bench: randomized samples and serial frames against an arithmetic gain-matrix model.
module tb_dual_ad7528_attenuator;

    logic        clk30 = 1'b0;
    logic        reset;
    logic        datadac;
    logic        clkdac;
    logic        csdac1n;
    logic        csdac2n;
    logic [15:0] audio_left_in;
    logic [15:0] audio_right_in;
    logic [15:0] audio_left_out;
    logic [15:0] audio_right_out;

    always #5 clk30 = ~clk30;

    dual_ad7528_attenuator dut (
        .clk30           (clk30),
        .reset           (reset),
        .datadac         (datadac),
        .clkdac          (clkdac),
        .csdac1n         (csdac1n),
        .csdac2n         (csdac2n),
        .audio_left_in   (audio_left_in),
        .audio_right_in  (audio_right_in),
        .audio_left_out  (audio_left_out),
        .audio_right_out (audio_right_out)
    );

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Model state: gains indexed 0=ll 1=rl 2=rr 3=lr, plus delayed updates.
    int   gain[4];
    int   pend_cnt[4];
    int   pend_val[4];
    int   frame_bits[$];
    int   bit_total;
    logic prev_cs1, prev_cs2, prev_clk;

    logic        use_fixed = 1'b0;
    logic [15:0] fixed_l = '0;
    logic [15:0] fixed_r = '0;

    function automatic logic [15:0] sat_model(input longint v);
        logic [63:0] bits;
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        bits = v;
        return bits[15:0];
    endfunction

    function automatic logic [15:0] pick_sample();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        gain = '{255, 0, 255, 0};
        for (int i = 0; i < 4; i++) pend_cnt[i] = 0;
        frame_bits.delete();
        bit_total = 0;
        prev_cs1 = 1'b1;
        prev_cs2 = 1'b1;
        prev_clk = 1'b0;
    endtask

    task automatic schedule(input int idx, input int code);
        pend_cnt[idx] = 2;
        pend_val[idx] = code;
    endtask

    // One clk30 cycle of stimulus: serial pins as given, audio random or fixed.
    task automatic applyStimulus(input logic d, input logic c, input logic cs1, input logic cs2);
        longint lv, rv;
        exp_t   e;
        int     code, ch;
        @(negedge clk30);
        for (int i = 0; i < 4; i++) begin
            if (pend_cnt[i] > 0) begin
                pend_cnt[i]--;
                if (pend_cnt[i] == 0) gain[i] = pend_val[i];
            end
        end
        datadac = d;
        clkdac  = c;
        csdac1n = cs1;
        csdac2n = cs2;
        audio_left_in  = use_fixed ? fixed_l : pick_sample();
        audio_right_in = use_fixed ? fixed_r : pick_sample();
        lv = longint'($signed(audio_left_in));
        rv = longint'($signed(audio_right_in));
        e.left  = sat_model((lv * gain[0] + rv * gain[1]) >>> 8);
        e.right = sat_model((rv * gain[2] + lv * gain[3]) >>> 8);
        exp_q.push_back(e);

        if ((!cs1 && prev_cs1) || (!cs2 && prev_cs2)) begin
            frame_bits.delete();
            bit_total = 0;
        end else if (c && !prev_clk && (!cs1 || !cs2)) begin
            frame_bits.push_back(int'(d));
            if (frame_bits.size() > 9) void'(frame_bits.pop_front());
            if (bit_total < 15) bit_total++;
        end
        if (((cs1 && !prev_cs1) || (cs2 && !prev_cs2)) && bit_total >= 9) begin
            ch = frame_bits[0];
            code = 0;
            for (int i = 1; i < 9; i++) code = code * 2 + frame_bits[i];
            if (cs1 && !prev_cs1) schedule(ch ? 1 : 0, code);
            if (cs2 && !prev_cs2) schedule(ch ? 3 : 2, code);
        end
        prev_cs1 = cs1;
        prev_cs2 = cs2;
        prev_clk = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // Frame is sent MSB first from bit n-1 of val; n may be short or long.
    task automatic send_frame(input logic en1, input logic en2, input logic [15:0] val, input int n);
        logic c1, c2;
        c1 = !en1;
        c2 = !en2;
        applyStimulus(1'b0, 1'b0, c1, c2);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(val[i], 1'b0, c1, c2);
            applyStimulus(val[i], 1'b1, c1, c2);
        end
        applyStimulus(1'b0, 1'b0, c1, c2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk30);
        reset   = 1'b1;
        datadac = 1'b0;
        clkdac  = 1'b0;
        csdac1n = 1'b1;
        csdac2n = 1'b1;
        @(posedge clk30);
        #1;
        checkOutput("reset_left", audio_left_out, 16'h0000);
        checkOutput("reset_right", audio_right_out, 16'h0000);
        repeat (2) @(negedge clk30);
        @(negedge clk30);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: every output sample after a pushed stimulus is compared in order.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk30);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("mix_left", audio_left_out, e.left);
                checkOutput("mix_right", audio_right_out, e.right);
            end
        end
    end

    initial begin
        reset = 1'b1;
        datadac = 1'b0;
        clkdac = 1'b0;
        csdac1n = 1'b1;
        csdac2n = 1'b1;
        audio_left_in = '0;
        audio_right_in = '0;
        model_reset();
        apply_reset();

        use_fixed = 1'b1;
        fixed_l = 16'h4000;
        fixed_r = 16'h1234;
        idle(4);

        send_frame(1'b1, 1'b0, 16'h0080, 9);
        idle(3);
        use_fixed = 1'b0;
        idle(6);

        send_frame(1'b0, 1'b1, 16'h01FF, 9);
        send_frame(1'b0, 1'b1, 16'h00FF, 9);
        use_fixed = 1'b1;
        fixed_l = 16'h7FFF;
        fixed_r = 16'h7FFF;
        idle(3);
        fixed_l = 16'h8000;
        fixed_r = 16'h8000;
        idle(3);

        send_frame(1'b1, 1'b0, 16'h00FF, 8);
        idle(3);

        use_fixed = 1'b0;
        send_frame(1'b1, 1'b0, 16'h0000, 9);
        idle(6);
        send_frame(1'b1, 1'b0, 16'h00FF, 9);
        use_fixed = 1'b1;
        fixed_l = 16'hFFFF;
        fixed_r = 16'h0000;
        idle(3);

        send_frame(1'b1, 1'b1, 16'h0140, 9);
        fixed_l = 16'h0000;
        fixed_r = 16'h4000;
        idle(3);

        use_fixed = 1'b0;
        send_frame(1'b1, 1'b0, 16'h0010, 9);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        apply_reset();
        idle(5);

        for (int f = 0; f < 40; f++) begin
            int sel;
            sel = $urandom_range(1, 3);
            send_frame(sel[0], sel[1], 16'($urandom), $urandom_range(7, 12));
            idle($urandom_range(0, 4));
        end

        begin
            int waited;
            waited = 0;
            while (exp_q.size() > 0 && waited < 20) begin
                @(posedge clk30);
                waited++;
            end
            #2;
            if (exp_q.size() > 0) begin
                mismatched++;
                $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
